serial_rx_ctrl: RTL and testbench

- Bit-level sequencer for the serial receive path: synchronises RDX, detects the start bit and times mid-bit samples with one reloadable down-counter.
- Assembles the data byte and checks the stop bit.
- Presents each byte on a valid/ready handshake with a one-entry holding register, plus sticky error flags.
- Sits between the RDX pin and the byte consumer (command decoder / FIFO).

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_bit_timer.sv | 44 ++++
 rtl/serial_rx_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_rx_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial receive path (and the planned
// transmitter): FSM state encodings, default parameters and the timer width
// helper.
// Optional feature macro used by the receiver: SERIAL_RX_PARITY_EN.
package serial_pkg;

  localparam int CLK_DIV_DEFAULT   = 651;
  localparam int DATA_BITS_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_START   = 3'd1;
  localparam state_t S_DATA    = 3'd2;
  localparam state_t S_PARITY  = 3'd3;
  localparam state_t S_STOP    = 3'd4;
  localparam state_t S_WAIT_HI = 3'd5;

  // Counter width able to hold CLK_DIV-1; never narrower than one bit.
  function automatic int tmr_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: reloadable bit-period down-counter.
// Ports:
//   m_clock, p_reset_n  clock / async active-low reset
//   load, load_val      start the timer from load_val (priority over counting)
//   halt                on expire, stop instead of reloading RELOAD
//   expire              counter is at zero while running
//   running             timer is armed
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int W      = 10,
  parameter int RELOAD = 650
) (
  input  logic         m_clock,
  input  logic         p_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         halt,
  output logic         expire,
  output logic         running
);

  logic [W-1:0] cnt;

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        if (halt) running <= 1'b0;
        else      cnt     <= W'(RELOAD);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl: serial receive bit sequencer.
// Synchronises rdx, finds the start bit, samples each bit at mid-period,
// checks the stop bit and hands bytes out through a one-entry holding
// register on a valid/ready handshake. Sticky frame/overrun/parity flags.
// Optional feature: define SERIAL_RX_PARITY_EN to add an even-parity bit
// between the data and stop bits (parity_err is tied low otherwise).
// Ports:
//   m_clock, p_reset_n   clock / async active-low reset
//   rdx                  serial line (idle high, asynchronous)
//   rx_data, rx_valid    received byte and its valid flag
//   rx_ready             consumer accepts on rx_valid & rx_ready
//   busy                 frame in progress
//   frame_err, overrun, parity_err  sticky error flags
//   clr_err              synchronous clear of the sticky flags
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 m_clock,
  input  logic                 p_reset_n,
  input  logic                 rdx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  input  logic                 clr_err
);

  localparam int          TW   = tmr_width(CLK_DIV);
  localparam logic [TW-1:0] HALF = TW'(CLK_DIV / 2 - 1);

  // Two-flop synchroniser; reset high so reset release is not a start edge.
  logic rdx_m, rdx_s;
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rdx_m <= 1'b1;
      rdx_s <= 1'b1;
    end else begin
      rdx_m <= rdx;
      rdx_s <= rdx_m;
    end
  end

  state_t               state, nxt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 expire, tmr_run, load, halt, last_bit;

  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));
  // A running timer is never restarted; IDLE always sees it halted.
  assign load     = (state == S_IDLE) && !rdx_s && !tmr_run;
  assign halt     = (nxt == S_IDLE) || (nxt == S_WAIT_HI);

  serial_bit_timer #(.W(TW), .RELOAD(CLK_DIV - 1)) u_tmr (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .load      (load),
    .load_val  (HALF),
    .halt      (halt),
    .expire    (expire),
    .running   (tmr_run)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (load) nxt = S_START;
      S_START:   if (expire) nxt = rdx_s ? S_IDLE : S_DATA;
`ifdef SERIAL_RX_PARITY_EN
      S_DATA:    if (expire && last_bit) nxt = S_PARITY;
      S_PARITY:  if (expire) nxt = S_STOP;
`else
      S_DATA:    if (expire && last_bit) nxt = S_STOP;
`endif
      S_STOP:    if (expire) nxt = rdx_s ? S_IDLE : S_WAIT_HI;
      S_WAIT_HI: if (rdx_s) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state <= nxt;
      if (state == S_START && expire) bit_idx <= '0;
      if (state == S_DATA && expire) begin
        shift[bit_idx] <= rdx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Stop-bit outcome; the holding register updates on the same edge so the
  // byte is visible in the cycle after the stop sample.
  logic stop_ok, stop_bad, take, accept, ovr_set;
  assign stop_ok  = (state == S_STOP) && expire && rdx_s;
  assign stop_bad = (state == S_STOP) && expire && !rdx_s;
  assign take     = rx_valid && rx_ready;
  assign accept   = stop_ok && (!rx_valid || rx_ready);
  assign ovr_set  = stop_ok && !accept;

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (accept) begin
      rx_data  <= shift;
      rx_valid <= 1'b1;
    end else if (take) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event beats a coincident clear.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits.
  logic par_set;
  assign par_set = (state == S_PARITY) && expire && ((^shift) != rdx_s);
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n)   parity_err <= 1'b0;
    else if (par_set) parity_err <= 1'b1;
    else if (clr_err) parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl with CLK_DIV=16, DATA_BITS=8.
// Line bits are driven on the falling clock edge, outputs sampled there too.
module tb_serial_rx_ctrl;

  logic       m_clock = 1'b0;
  logic       p_reset_n = 1'b0;
  logic       rdx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun, parity_err;

  serial_rx_ctrl #(.CLK_DIV(16), .DATA_BITS(8)) dut (
    .m_clock    (m_clock),
    .p_reset_n  (p_reset_n),
    .rdx        (rdx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .clr_err    (clr_err)
  );

  always #5 m_clock = ~m_clock;

`ifdef SERIAL_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  int         checks = 0;
  int         failures = 0;
  int         cyc, first_cyc, nvalid;
  logic [7:0] got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge m_clock);
    cyc++;
    if (rx_valid) begin
      nvalid++;
      if (nvalid == 1) begin
        first_cyc = cyc;
        got       = rx_data;
      end
    end
  endtask

  task automatic line(input logic v, input int n);
    rdx = v;
    repeat (n) tick();
  endtask

  task automatic mon_clr();
    cyc = 0; nvalid = 0; first_cyc = -1; got = 8'h00;
  endtask

  task automatic send(input logic [7:0] d, input logic stopv, input int stopn, input logic pflip);
    line(1'b0, 16);
    for (int i = 0; i < 8; i++) line(d[i], 16);
`ifdef SERIAL_RX_PARITY_EN
    line((^d) ^ pflip, 16);
`else
    if (pflip) line(1'b1, 0);
`endif
    line(stopv, stopn);
  endtask

  function automatic logic lat_ok(input int c);
    return (c >= LAT - 1) && (c <= LAT + 1);
  endfunction

  initial begin
    mon_clr();
    // Reset state
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    p_reset_n = 1'b1;
    line(1'b1, 10);

    // Single frame, consumer always ready
    rx_ready = 1'b1;
    mon_clr();
    send(8'hA5, 1'b1, 16, 1'b0);
    line(1'b1, 10);
    check("a5_lat", lat_ok(first_cyc), 1);
    check("a5_data", got, 8'hA5);
    check("a5_pulse", nvalid, 1);
    check("a5_ferr", frame_err, 0);
    check("a5_ovr", overrun, 0);
    check("a5_busy", busy, 0);

    // Back-to-back frames with no consumer: second byte is dropped
    rx_ready = 1'b0;
    mon_clr();
    send(8'h3C, 1'b1, 16, 1'b0);
    send(8'hC3, 1'b1, 16, 1'b0);
    line(1'b1, 10);
    check("b2b_lat", lat_ok(first_cyc), 1);
    check("b2b_valid", rx_valid, 1);
    check("b2b_data", rx_data, 8'h3C);
    check("b2b_ovr", overrun, 1);
    rx_ready = 1'b1;
    tick();
    check("b2b_drain", rx_valid, 0);
    check("b2b_ovr_hold", overrun, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("b2b_clr", overrun, 0);

    // Short low glitch aborts in START
    mon_clr();
    line(1'b0, 5);
    check("gl_busy", busy, 1);
    line(1'b1, 20);
    check("gl_idle", busy, 0);
    check("gl_novalid", nvalid, 0);
    check("gl_ferr", frame_err, 0);

    // Stop bit held low (break), then a good frame
    mon_clr();
    send(8'h55, 1'b0, 40, 1'b0);
    check("brk_busy", busy, 1);
    check("brk_ferr", frame_err, 1);
    check("brk_novalid", nvalid, 0);
    line(1'b1, 5);
    check("brk_idle", busy, 0);
    mon_clr();
    send(8'h12, 1'b1, 16, 1'b0);
    line(1'b1, 10);
    check("after_brk_data", got, 8'h12);
    check("after_brk_pulse", nvalid, 1);

    // Reset in the middle of the 4th data bit
    mon_clr();
    line(1'b0, 16);
    for (int i = 0; i < 3; i++) line(1'b1, 16);
    line(1'b1, 8);
    check("pre_rst_busy", busy, 1);
    p_reset_n = 1'b0;
    tick();
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_valid", rx_valid, 0);
    tick();
    tick();
    p_reset_n = 1'b1;
    line(1'b1, 20);
    mon_clr();
    send(8'h81, 1'b1, 16, 1'b0);
    line(1'b1, 10);
    check("r81_lat", lat_ok(first_cyc), 1);
    check("r81_data", got, 8'h81);
    check("r81_pulse", nvalid, 1);

`ifdef SERIAL_RX_PARITY_EN
    // Wrong parity still delivers the byte
    mon_clr();
    send(8'h07, 1'b1, 16, 1'b1);
    line(1'b1, 10);
    check("par_err", parity_err, 1);
    check("par_data", got, 8'h07);
    check("par_pulse", nvalid, 1);
`else
    check("par_tied", parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
